ks_phase_aligner: RTL and testbench

- Successor to the single-shape GCM phase bypasser. Aligns an AES-CTR keystream with a packet text stream whose payload starts SHIFT_BYTES into a keystream block.
- Header beats pass through with a zero key and consume no keystream.
- Body beats are paired with a byte-shifted keystream word that stitches the previous keystream beat's tail to the current beat.
- Sits between the CTR keystream generator and the XOR/GHASH stage. Full valid/ready handshakes on all three streams; one registered output stage.

---
 rtl/ks_align_pkg.sv | 20 ++
 rtl/ks_shift_stitch.sv | 28 ++
 rtl/ks_phase_aligner.sv | 155 +++++++++++++++
 tb/tb_ks_phase_aligner.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_align_pkg.sv
// ks_align_pkg: shared types and width helpers for the keystream aligner.
package ks_align_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } ks_state_e;

  function automatic int calc_ks_w(input int lanes);
    return lanes * AES_BLK_W;
  endfunction

  function automatic int calc_txt_w(input int lanes, input int meta_w);
    return calc_ks_w(lanes) + meta_w;
  endfunction

endpackage

// File: rtl/ks_shift_stitch.sv
// ks_shift_stitch: joins the previous beat's keystream tail to the current beat.
// Purely combinational; a zero shift passes the keystream straight through.
module ks_shift_stitch #(
  parameter int KS_W        = 256,
  parameter int SHIFT_BYTES = 2,
  parameter int CW          = (SHIFT_BYTES > 0) ? 8 * SHIFT_BYTES : 1
) (
  input  logic [CW-1:0]   carry,
  input  logic [KS_W-1:0] k_data,
  output logic [KS_W-1:0] key,
  output logic [CW-1:0]   carry_next
);

  localparam int SHIFT_W = 8 * SHIFT_BYTES;

  generate
    if (SHIFT_W == 0) begin : g_pass
      logic unused_carry;
      assign unused_carry = ^carry;
      assign key          = k_data;
      assign carry_next   = '0;
    end else begin : g_shift
      assign key        = {carry, k_data[KS_W-1:SHIFT_W]};
      assign carry_next = k_data[SHIFT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/ks_phase_aligner.sv
// ks_phase_aligner: pairs text beats with a phase-shifted CTR keystream.
// Optional KSA_LAST_MASK_EN zeroes key bytes beyond s_keep on the last body beat.
module ks_phase_aligner
  import ks_align_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int META_W      = 33,
  parameter int SHIFT_BYTES = 2,
  parameter int HDR_BEATS   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [calc_txt_w(LANES, META_W)-1:0]  s_text,
  input  logic                                  s_first,
  input  logic                                  s_last,
  input  logic [calc_ks_w(LANES)/8-1:0]         s_keep,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [calc_ks_w(LANES)-1:0]           k_data,
  input  logic                                  k_valid,
  output logic                                  k_ready,
  output logic [calc_txt_w(LANES, META_W)-1:0]  m_text,
  output logic [calc_ks_w(LANES)-1:0]           m_key,
  output logic                                  m_last,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic                                  err
);

  localparam int KS_W    = calc_ks_w(LANES);
  localparam int TXT_W   = calc_txt_w(LANES, META_W);
  localparam int SHIFT_W = 8 * SHIFT_BYTES;
  localparam int CW      = (SHIFT_W > 0) ? SHIFT_W : 1;
  localparam logic [3:0] HDR_N = 4'(HDR_BEATS);

  ks_state_e       state, state_n;
  logic [3:0]      hdr_cnt, cnt_n;
  logic [CW-1:0]   carry, carry_in, carry_next;
  logic [KS_W-1:0] stitched, key;
  logic            slot_free, fire, err_n;
  logic            hdr_cls, body_cls, drop;

  assign slot_free = !m_valid || m_ready;

  // A first beat always restarts classification, whatever the state.
  always_comb begin
    hdr_cls  = 1'b0;
    body_cls = 1'b0;
    drop     = 1'b0;
    if (s_first) begin
      if (HDR_BEATS > 0) hdr_cls = 1'b1;
      else               body_cls = 1'b1;
    end else begin
      unique case (state)
        ST_HDR:  hdr_cls  = 1'b1;
        ST_BODY: body_cls = 1'b1;
        default: drop     = 1'b1;
      endcase
    end
  end

  assign s_ready = body_cls ? (slot_free && k_valid) : slot_free;
  assign k_ready = body_cls && slot_free && s_valid;
  assign fire    = s_valid && s_ready;

  assign carry_in = s_first ? '0 : carry;

  ks_shift_stitch #(
    .KS_W        (KS_W),
    .SHIFT_BYTES (SHIFT_BYTES),
    .CW          (CW)
  ) u_stitch (
    .carry      (carry_in),
    .k_data     (k_data),
    .key        (stitched),
    .carry_next (carry_next)
  );

  always_comb begin
    key = body_cls ? stitched : '0;
`ifdef KSA_LAST_MASK_EN
    if (body_cls && s_last) begin
      for (int i = 0; i < KS_W / 8; i++) begin
        if (!s_keep[i]) key[8*i +: 8] = 8'h00;
      end
    end
`else
    begin : g_keep_sink
      logic unused_keep;
      unused_keep = ^s_keep;
    end
`endif
  end

  always_comb begin
    state_n = state;
    cnt_n   = hdr_cnt;
    if (fire) begin
      unique case (1'b1)
        s_first: begin
          if (HDR_BEATS <= 1) begin
            state_n = ST_BODY;
          end else begin
            state_n = ST_HDR;
            cnt_n   = 4'd1;
          end
        end
        (!s_first && state == ST_HDR): begin
          cnt_n = hdr_cnt + 4'd1;
          if (cnt_n == HDR_N) state_n = ST_BODY;
        end
        default: ;
      endcase
      if (s_last) begin
        state_n = ST_IDLE;
        cnt_n   = 4'd0;
      end
    end
  end

  assign err_n = fire && (drop || (s_first && state != ST_IDLE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      hdr_cnt <= 4'd0;
      carry   <= '0;
      m_text  <= '0;
      m_key   <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      hdr_cnt <= cnt_n;
      err     <= err_n;
      if (fire && !drop) begin
        m_text  <= s_text;
        m_key   <= key;
        m_last  <= s_last;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (fire) begin
        if (body_cls)     carry <= carry_next;
        else if (s_first) carry <= '0;
      end
    end
  end

  logic unused_w;
  assign unused_w = (TXT_W == 0);

endmodule

// File: tb/tb_ks_phase_aligner.sv
// tb_ks_phase_aligner: directed vectors plus randomized traffic against a
// packet-level reference model of the keystream alignment.
module tb_ks_phase_aligner;

  localparam int KS_W    = 256;
  localparam int TXT_W   = 289;
  localparam int NB      = 32;
  localparam int SHIFT_W = 16;
  localparam int HDRS    = 1;

  localparam logic [KS_W-1:0] K0 =
    256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20;
  localparam logic [KS_W-1:0] K1 =
    256'hA1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBFC0;
  localparam logic [KS_W-1:0] EK1 =
    256'h0000_0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E;
  localparam logic [KS_W-1:0] EK2 =
    256'h1F20_A1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7B8B9BABBBCBDBE;

  logic             clk = 1'b0;
  logic             rst;
  logic [TXT_W-1:0] s_text;
  logic             s_first, s_last, s_valid, s_ready;
  logic [NB-1:0]    s_keep;
  logic [KS_W-1:0]  k_data;
  logic             k_valid, k_ready;
  logic [TXT_W-1:0] m_text;
  logic [KS_W-1:0]  m_key;
  logic             m_last, m_valid, m_ready, err;

  int checks   = 0;
  int failures = 0;
  int kfire_cnt = 0;

  always #5 clk = ~clk;

  ks_phase_aligner dut (
    .clk     (clk),
    .rst     (rst),
    .s_text  (s_text),
    .s_first (s_first),
    .s_last  (s_last),
    .s_keep  (s_keep),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .k_data  (k_data),
    .k_valid (k_valid),
    .k_ready (k_ready),
    .m_text  (m_text),
    .m_key   (m_key),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .err     (err)
  );

  task automatic chk(input string nm, input logic [319:0] act,
                     input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [TXT_W-1:0] rtext();
    logic [319:0] w;
    for (int i = 0; i < 10; i++) w[32*i +: 32] = $urandom;
    return w[TXT_W-1:0];
  endfunction

  function automatic logic [KS_W-1:0] rks();
    logic [KS_W-1:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  // Reference model: packets as beat positions, keystream as a byte stream
  // that starts SHIFT_W bits of zeros ahead of the first body keystream word.
  typedef struct {
    logic [TXT_W-1:0] text;
    logic [KS_W-1:0]  key;
    logic             last;
  } exp_t;

  exp_t            exp_q[$];
  bit              in_pkt   = 0;
  int              pos      = 0;
  logic [KS_W-1:0] prev_ks  = '0;
  logic            pend_err = 0;
  bit              held     = 0;
  logic [TXT_W-1:0] h_text;
  logic [KS_W-1:0]  h_key;

  always @(negedge clk) begin
    logic fire, kf, body, ndrop;
    logic [2*KS_W-1:0] wide;
    exp_t e;
    if (rst) begin
      exp_q.delete();
      in_pkt   = 0;
      pos      = 0;
      pend_err = 0;
      held     = 0;
    end else begin
      chk("err_pulse", err, pend_err);
      if (held) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_text", m_text, h_text);
        chk("hold_key", m_key, h_key);
      end
      held   = m_valid && !m_ready;
      h_text = m_text;
      h_key  = m_key;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("out_text", m_text, e.text);
          chk("out_key", m_key, e.key);
          chk("out_last", m_last, e.last);
        end
      end
      fire     = s_valid && s_ready;
      kf       = k_valid && k_ready;
      pend_err = 0;
      body     = 0;
      if (fire) begin
        ndrop = 1;
        if (s_first) begin
          if (in_pkt) pend_err = 1;
          in_pkt  = 1;
          pos     = 0;
          prev_ks = '0;
        end else if (!in_pkt) begin
          pend_err = 1;
          ndrop    = 0;
        end
        if (ndrop) begin
          e.text = s_text;
          e.last = s_last;
          if (pos < HDRS) begin
            e.key = '0;
          end else begin
            body    = 1;
            wide    = {prev_ks, k_data} >> SHIFT_W;
            e.key   = wide[KS_W-1:0];
            prev_ks = k_data;
`ifdef KSA_LAST_MASK_EN
            if (s_last)
              for (int b = 0; b < NB; b++)
                if (!s_keep[b]) e.key[8*b +: 8] = 8'h00;
`endif
          end
          exp_q.push_back(e);
          pos++;
          if (s_last) in_pkt = 0;
        end
      end
      chk("k_consume", kf, fire && body);
      if (kf) kfire_cnt++;
    end
  end

  task automatic drive_beat(input logic f, input logic l,
                            input logic [NB-1:0] kp,
                            input logic [KS_W-1:0] kd, output logic kr);
    int n = 0;
    s_valid = 1; s_first = f; s_last = l; s_keep = kp;
    s_text  = rtext(); k_valid = 1; k_data = kd;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) chk("beat_timeout", 1'b1, 1'b0);
    kr = k_ready;
    @(posedge clk); #1;
    s_valid = 0; k_valid = 0; s_first = 0; s_last = 0;
  endtask

  task automatic drain();
    s_valid = 0; k_valid = 0; m_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic            first, last, drop, kready;
    logic [KS_W-1:0] k, key;
  } vec_t;

  initial begin
    vec_t vt[5];
    logic kr, sf, kf;
    int   k_before, rem, sent;

    vt[0] = '{first: 1, last: 0, drop: 0, kready: 0, k: K0, key: '0};
    vt[1] = '{first: 0, last: 0, drop: 0, kready: 1, k: K0, key: EK1};
    vt[2] = '{first: 0, last: 1, drop: 0, kready: 1, k: K1, key: EK2};
    vt[3] = '{first: 0, last: 0, drop: 1, kready: 0, k: K1, key: '0};
    vt[4] = '{first: 1, last: 1, drop: 0, kready: 0, k: K1, key: '0};

    rst = 1; s_valid = 0; s_first = 0; s_last = 0; s_keep = '1;
    s_text = '0; k_data = '0; k_valid = 0; m_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_key", m_key, '0);
    chk("rst_m_text", m_text, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_k_ready", k_ready, 1'b0);
    rst = 0;
    @(posedge clk); #1;

    k_before = kfire_cnt;
    for (int i = 0; i < 5; i++) begin
      drive_beat(vt[i].first, vt[i].last, '1, vt[i].k, kr);
      chk($sformatf("v%0d_k_ready", i), kr, vt[i].kready);
      chk($sformatf("v%0d_m_valid", i), m_valid, !vt[i].drop);
      if (!vt[i].drop) chk($sformatf("v%0d_m_key", i), m_key, vt[i].key);
      chk($sformatf("v%0d_err", i), err, vt[i].drop);
      if (i == 2) chk("pkt_k_pulses", kfire_cnt - k_before, 2);
    end
    drain();

    // s_first in the middle of a body restarts with a clean carry
    drive_beat(1, 0, '1, K0, kr);
    drive_beat(0, 0, '1, K0, kr);
    drive_beat(1, 0, '1, K1, kr);
    chk("restart_err", err, 1'b1);
    chk("restart_key", m_key, '0);
    drive_beat(0, 1, '1, K1, kr);
    chk("restart_err_clear", err, 1'b0);
    chk("restart_carry", m_key[KS_W-1:KS_W-16], 16'h0000);
    drain();

    // keystream starvation in body
    drive_beat(1, 0, '1, K0, kr);
    s_valid = 1; s_first = 0; s_last = 0; s_text = rtext();
    k_valid = 0; k_data = K1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("starve_s_ready", s_ready, 1'b0);
      if (i > 0) chk("starve_m_valid", m_valid, 1'b0);
    end
    @(posedge clk); #1;
    k_valid = 1;
    @(negedge clk);
    chk("starve_resume", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 0; k_valid = 0;
    chk("starve_out", m_valid, 1'b1);
    drive_beat(0, 1, '1, K0, kr);
    drain();

    // downstream backpressure with a body beat pending
    m_ready = 0;
    s_valid = 1; s_first = 1; s_last = 0; s_text = rtext();
    k_valid = 1; k_data = K0;
    @(posedge clk); #1;
    s_first = 0; s_text = rtext();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_s_ready", s_ready, 1'b0);
      chk("bp_m_valid", m_valid, 1'b1);
    end
    @(posedge clk); #1;
    m_ready = 1;
    @(negedge clk);
    chk("bp_release", s_ready, 1'b1);
    @(posedge clk); #1;
    s_last = 1; s_text = rtext(); k_data = K1;
    @(negedge clk);
    chk("bp_nogap_v", m_valid, 1'b1);
    chk("bp_nogap_r", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 0; k_valid = 0; s_last = 0;
    @(negedge clk);
    chk("bp_last_out", m_valid, 1'b1);
    drain();

    // asynchronous reset mid-packet
    drive_beat(1, 0, '1, K0, kr);
    drive_beat(0, 0, '1, K0, kr);
    #1 rst = 1;
    #1;
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_m_key", m_key, '0);
    chk("arst_m_text", m_text, '0);
    chk("arst_m_last", m_last, 1'b0);
    chk("arst_err", err, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    drive_beat(1, 0, '1, K1, kr);
    chk("arst_hdr_key", m_key, '0);
    chk("arst_hdr_valid", m_valid, 1'b1);
    drive_beat(0, 1, '1, K0, kr);
    chk("arst_body_key", m_key, EK1);
    drain();

`ifdef KSA_LAST_MASK_EN
    drive_beat(1, 0, '1, K0, kr);
    drive_beat(0, 1, 32'h0000_FFFF, K1, kr);
    chk("mask_hi", m_key[255:128], '0);
    chk("mask_lo", m_key[127:0], K1[143:16]);
    drain();
`endif

    // randomized traffic
    rem = 0; sent = 0;
    for (int c = 0; c < 4000 && sent < 400; c++) begin
      @(negedge clk);
      sf = s_valid && s_ready;
      kf = k_valid && k_ready;
      if (sf) sent++;
      @(posedge clk); #1;
      m_ready = ($urandom_range(0, 3) != 0);
      if (!k_valid || kf) begin
        k_valid = ($urandom_range(0, 4) != 0);
        k_data  = rks();
      end
      if (!s_valid || sf) begin
        if ($urandom_range(0, 3) != 0) begin
          if (rem == 0) begin
            rem = $urandom_range(1, 5);
            s_first = 1;
          end else begin
            s_first = 0;
          end
          s_last  = (rem == 1);
          rem--;
          s_valid = 1;
          s_text  = rtext();
          s_keep  = ($urandom_range(0, 1) != 0) ? '1 : NB'($urandom);
        end else begin
          s_valid = 0;
        end
      end
    end
    chk("rand_progress", sent >= 100, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
